// File: rtl/sp_sram_coeff_ctrl.sv
// rtl/sp_sram_coeff_ctrl.sv - coefficient SRAM initiator: host write forwarding and indexed read sweep
module sp_sram_coeff_ctrl #(
    parameter int DEPTH = 10,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic          iClk_12M,
    input  logic          iRsn,
    input  logic          iCoeffUpdateFlag,
    input  logic          iWrEn,
    input  logic [AW-1:0] iWrAddr,
    input  logic [DW-1:0] iWrDt,
    input  logic          iStart,
    output logic          oCsnRam,
    output logic          oWrnRam,
    output logic [AW-1:0] oAddrRam,
    output logic [DW-1:0] oWrDtRam,
    input  logic [DW-1:0] iRdDtRam,
    output logic [DW-1:0] oCoeff,
    output logic [AW-1:0] oCoeffIdx,
    output logic          oCoeffValid,
    output logic          oBusy,
    output logic          oDone,
    output logic          oWrErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_rd_cnt;
    logic [AW-1:0] r_rd_idx;
    logic          r_rd_pend;
    logic          r_wr_err;

    logic w_start;
    logic w_addr_ok;
    logic w_wr_acc;
    logic w_rd_act;

    assign w_start   = iStart & ~iCoeffUpdateFlag;
    assign w_addr_ok = (iWrAddr <= LAST);
    assign w_wr_acc  = (r_state == S_IDLE) & iCoeffUpdateFlag & iWrEn & w_addr_ok;
    assign w_rd_act  = (r_state == S_READ);

    // SRAM read data arrives one edge after the address, so valid/index trail the read by one cycle
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state   <= S_IDLE;
            r_rd_cnt  <= '0;
            r_rd_idx  <= '0;
            r_rd_pend <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_act;
            r_rd_idx  <= r_rd_cnt;
            r_wr_err  <= iWrEn & ~w_wr_acc;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_READ;
                        r_rd_cnt <= '0;
                    end
                end
                S_READ: begin
                    if (r_rd_cnt == LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_start) begin
                        r_state  <= S_READ;
                        r_rd_cnt <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // SRAM strobes are forced inactive while reset is low, independent of the write inputs
    assign oCsnRam  = ~iRsn | ~(w_rd_act | w_wr_acc);
    assign oWrnRam  = ~iRsn | ~w_wr_acc;
    assign oAddrRam = !iRsn    ? '0 :
                      w_rd_act ? r_rd_cnt :
                      w_wr_acc ? iWrAddr : '0;
    assign oWrDtRam = (iRsn & w_wr_acc) ? iWrDt : '0;

    assign oCoeff      = r_rd_pend ? iRdDtRam : '0;
    assign oCoeffIdx   = r_rd_idx;
    assign oCoeffValid = r_rd_pend;
    assign oBusy       = (r_state != S_IDLE);
    assign oDone       = (r_state == S_DONE);
    assign oWrErr      = r_wr_err;

endmodule
